// File: rtl/fp_mul_arbiter.sv
`default_nettype none
//============================================================================
// Module      : fp_mul_arbiter
// Description : Shares one pipelined FP multiplier between two requesters
//               of the inverse-sqrt datapath. Requester 0 is the
//               Newton-Raphson path and requester 1 is the final scaling
//               path. Round-robin grant, one issue per cycle, results
//               routed back through a tag shift register, per-requester
//               outstanding limit, sticky flag for lost results.
// Revision    : 1.0 - initial release
//
// Parameters  : LAT     - multiplier latency, mul_valid to mul_ready (>=1)
//               MAX_OUT - in-flight limit per requester (1..15)
// Option macro: FP_MUL_ARB_CNT_EN adds grant_cnt0, grant_cnt1, starve
//
// Ports       : clk, rst_n              clock, async active-low reset
//               reqN_valid/a/b/err      operand pair + error tag from N
//               reqN_ready              grant (combinational)
//               mul_valid/a/b/err       registered issue to multiplier
//               mul_ready/result/err_in multiplier result strobe + data
//               rspN_valid/data/err     one-cycle result pulse to N
//               proto_err               sticky: expected result missing
//               grant_cnt0/1, starve    (optional) statistics hooks
//============================================================================
module fp_mul_arbiter #(
   parameter int LAT     = 2,
   parameter int MAX_OUT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [30:0] req0_a,
   input  logic [30:0] req0_b,
   input  logic        req0_err,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [30:0] req1_a,
   input  logic [30:0] req1_b,
   input  logic        req1_err,
   output logic        req1_ready,
   output logic        mul_valid,
   output logic [30:0] mul_a,
   output logic [30:0] mul_b,
   output logic        mul_err,
   input  logic        mul_ready,
   input  logic [30:0] mul_result,
   input  logic        mul_err_in,
   output logic        rsp0_valid,
   output logic [30:0] rsp0_data,
   output logic        rsp0_err,
   output logic        rsp1_valid,
   output logic [30:0] rsp1_data,
   output logic        rsp1_err,
`ifdef FP_MUL_ARB_CNT_EN
   output logic [15:0] grant_cnt0,
   output logic [15:0] grant_cnt1,
   output logic        starve,
`endif
   output logic        proto_err
);

   localparam logic [3:0] C_MAX_OUT = 4'(MAX_OUT);

   logic [3:0]   r_out0;
   logic [3:0]   r_out1;
   logic         r_last;
   // Tag pipe: bit 0 is aligned with mul_valid, bit LAT with mul_ready.
   logic [LAT:0] r_tag_v;
   logic [LAT:0] r_tag_id;

   logic       w_elig0, w_elig1;
   logic       w_grant0, w_grant1;
   logic       w_hs, w_gid;
   logic       w_exp_v, w_exp_id;
   logic       w_cons0, w_cons1;
   logic [3:0] w_out0_nxt, w_out1_nxt;

   assign w_elig0 = req0_valid && (r_out0 < C_MAX_OUT);
   assign w_elig1 = req1_valid && (r_out1 < C_MAX_OUT);

   // r_last = 1 means requester 1 was served last, so requester 0 wins a tie.
   assign w_grant0 = w_elig0 && (!w_elig1 || r_last);
   assign w_grant1 = w_elig1 && (!w_elig0 || !r_last);

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;

   assign w_hs  = w_grant0 | w_grant1;
   assign w_gid = w_grant1;

   assign w_exp_v  = r_tag_v[LAT];
   assign w_exp_id = r_tag_id[LAT];
   // A tag is consumed whether or not the result arrives, so a lost result
   // still frees its outstanding slot.
   assign w_cons0  = w_exp_v && !w_exp_id;
   assign w_cons1  = w_exp_v &&  w_exp_id;

   always_comb begin
      w_out0_nxt = r_out0;
      if (w_grant0 && !w_cons0)
         w_out0_nxt = r_out0 + 4'd1;
      else if (!w_grant0 && w_cons0 && (r_out0 != 4'd0))
         w_out0_nxt = r_out0 - 4'd1;
   end

   always_comb begin
      w_out1_nxt = r_out1;
      if (w_grant1 && !w_cons1)
         w_out1_nxt = r_out1 + 4'd1;
      else if (!w_grant1 && w_cons1 && (r_out1 != 4'd0))
         w_out1_nxt = r_out1 - 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_valid  <= 1'b0;
         mul_a      <= '0;
         mul_b      <= '0;
         mul_err    <= 1'b0;
         r_tag_v    <= '0;
         r_tag_id   <= '0;
         r_out0     <= '0;
         r_out1     <= '0;
         r_last     <= 1'b1;
         rsp0_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp0_err   <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_data  <= '0;
         rsp1_err   <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         mul_valid <= w_hs;
         if (w_hs) begin
            mul_a   <= w_gid ? req1_a   : req0_a;
            mul_b   <= w_gid ? req1_b   : req0_b;
            mul_err <= w_gid ? req1_err : req0_err;
            r_last  <= w_gid;
         end

         r_tag_v  <= {r_tag_v[LAT-1:0],  w_hs};
         r_tag_id <= {r_tag_id[LAT-1:0], w_gid};

         r_out0 <= w_out0_nxt;
         r_out1 <= w_out1_nxt;

         // mul_ready without a valid tag is stale data from before a reset
         // (the multiplier itself is not reset) and is dropped silently.
         rsp0_valid <= w_cons0 && mul_ready;
         if (w_cons0 && mul_ready) begin
            rsp0_data <= mul_result;
            rsp0_err  <= mul_err_in;
         end
         rsp1_valid <= w_cons1 && mul_ready;
         if (w_cons1 && mul_ready) begin
            rsp1_data <= mul_result;
            rsp1_err  <= mul_err_in;
         end

         if (w_exp_v && !mul_ready)
            proto_err <= 1'b1;
      end
   end

`ifdef FP_MUL_ARB_CNT_EN
   logic [3:0] r_wait0, r_wait1;
   logic       w_stv0, w_stv1;

   // Waiting while eligible; the arbiter should never let this reach 8.
   assign w_stv0 = req0_valid && !req0_ready && (r_out0 < C_MAX_OUT);
   assign w_stv1 = req1_valid && !req1_ready && (r_out1 < C_MAX_OUT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
         r_wait0    <= '0;
         r_wait1    <= '0;
         starve     <= 1'b0;
      end else begin
         if (w_grant0 && (grant_cnt0 != 16'hFFFF))
            grant_cnt0 <= grant_cnt0 + 16'd1;
         if (w_grant1 && (grant_cnt1 != 16'hFFFF))
            grant_cnt1 <= grant_cnt1 + 16'd1;
         r_wait0 <= w_stv0 ? ((r_wait0 == 4'd8) ? r_wait0 : r_wait0 + 4'd1) : 4'd0;
         r_wait1 <= w_stv1 ? ((r_wait1 == 4'd8) ? r_wait1 : r_wait1 + 4'd1) : 4'd0;
         // Fires once, on the 8th consecutive waiting cycle.
         starve  <= (w_stv0 && (r_wait0 == 4'd7)) || (w_stv1 && (r_wait1 == 4'd7));
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_fp_mul_arbiter
// Description : Self-checking bench for fp_mul_arbiter. Models the
//               requesters and a fixed-latency multiplier, and predicts
//               every DUT output from an operation-level scoreboard.
// Revision    : 1.0 - initial release
//============================================================================
module tb_fp_mul_arbiter;

   // LAT=3 makes the issue-to-release loop longer than MAX_OUT, so the
   // outstanding limit actually throttles a continuously valid requester.
   localparam int LAT     = 3;
   localparam int MAX_OUT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_err, req0_ready;
   logic [30:0] req0_a, req0_b;
   logic        req1_valid, req1_err, req1_ready;
   logic [30:0] req1_a, req1_b;
   logic        mul_valid, mul_err, mul_ready, mul_err_in;
   logic [30:0] mul_a, mul_b, mul_result;
   logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
   logic [30:0] rsp0_data, rsp1_data;
   logic        proto_err;
`ifdef FP_MUL_ARB_CNT_EN
   logic [15:0] grant_cnt0, grant_cnt1;
   logic        starve;
`endif

   always #5 clk = ~clk;

   fp_mul_arbiter #(.LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
      .req0_err(req0_err), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
      .req1_err(req1_err), .req1_ready(req1_ready),
      .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_err(mul_err),
      .mul_ready(mul_ready), .mul_result(mul_result), .mul_err_in(mul_err_in),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
`ifdef FP_MUL_ARB_CNT_EN
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .starve(starve),
`endif
      .proto_err(proto_err)
   );

   typedef struct {
      int          due;
      bit          id;
      logic [30:0] res;
      logic        err;
      bit          lose;
      bit          stale;
   } op_t;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Scoreboard of operations accepted by the arbiter, oldest first.
   op_t q[$];
   int  mout[2];
   bit  mlast;

   // Predicted registered outputs for the next sample point.
   logic        e_mv, e_me, e_proto;
   logic [30:0] e_ma, e_mb;
   logic        e_rv[2];
   logic [30:0] e_rd[2];
   logic        e_re[2];

   // Requester models.
   bit          pend[2];
   logic [30:0] pa[2], pb[2];
   logic        perr[2];
   int          pct[2];
   int          lose_pct, flip_pct, rst_pct;
   bit          rst_now, lose_next;
   bit          dir_en;
   int          dir_id;
   logic [30:0] dir_a, dir_b;
   logic        dir_err;

   // Observation bookkeeping for the directed scenarios.
   int  gseq[$];
   int  obs_hs0, obs_rsp0, hs_at_first_rsp0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, want);
      end
   endtask

   // Truncating multiply of positive normal floats (exponents kept in range).
   function automatic logic [30:0] fmul(input logic [30:0] a, input logic [30:0] b);
      logic [47:0] p;
      logic [8:0]  e;
      logic [22:0] m;
      p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
      if (p[47]) begin
         m = p[46:24];
         e = 9'(a[30:23]) + 9'(b[30:23]) - 9'd126;
      end else begin
         m = p[45:23];
         e = 9'(a[30:23]) + 9'(b[30:23]) - 9'd127;
      end
      return {e[7:0], m};
   endfunction

   function automatic logic [30:0] rnd_op();
      logic [7:0] e;
      e = 8'(110 + $urandom_range(0, 35));
      return {e, 23'($urandom)};
   endfunction

   task automatic model_reset();
      e_mv = 0; e_me = 0; e_proto = 0; e_ma = '0; e_mb = '0;
      for (int i = 0; i < 2; i++) begin
         e_rv[i] = 0; e_rd[i] = '0; e_re[i] = 0; mout[i] = 0;
      end
      mlast = 1;
   endtask

   // One clock cycle: check registered outputs, drive inputs, check ready,
   // then advance the reference model across the coming edge.
   task automatic step();
      int  g;
      bit  elig[2];
      bit  due_now;
      op_t op;

      @(posedge clk); #1;
      cyc++;
      chk("mul_valid", mul_valid, e_mv);
      chk("mul_a", mul_a, e_ma);
      chk("mul_b", mul_b, e_mb);
      if (e_mv) chk("mul_err", mul_err, e_me);
      chk("rsp0_valid", rsp0_valid, e_rv[0]);
      chk("rsp0_data", rsp0_data, e_rd[0]);
      chk("rsp0_err", rsp0_err, e_re[0]);
      chk("rsp1_valid", rsp1_valid, e_rv[1]);
      chk("rsp1_data", rsp1_data, e_rd[1]);
      chk("rsp1_err", rsp1_err, e_re[1]);
      chk("proto_err", proto_err, e_proto);
      if (rsp0_valid) begin
         if (hs_at_first_rsp0 < 0) hs_at_first_rsp0 = obs_hs0;
         obs_rsp0++;
      end

      if (rst_now || ($urandom_range(0, 999) < rst_pct)) rst_n = 1'b0;
      else rst_n = 1'b1;
      rst_now = 0;

      for (int i = 0; i < 2; i++) begin
         if (!rst_n) pend[i] = 0;
         else if (!pend[i] && ((dir_en && dir_id == i) || ($urandom_range(0, 99) < pct[i]))) begin
            pend[i] = 1;
            if (dir_en && dir_id == i) begin
               pa[i] = dir_a; pb[i] = dir_b; perr[i] = dir_err; dir_en = 0;
            end else begin
               pa[i] = rnd_op(); pb[i] = rnd_op(); perr[i] = ($urandom_range(0, 9) == 0);
            end
         end
      end
      req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0]; req0_err = perr[0];
      req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1]; req1_err = perr[1];

      due_now = (q.size() > 0) && (q[0].due == cyc);
      if (due_now) begin
         mul_ready = !q[0].lose; mul_result = q[0].res; mul_err_in = q[0].err;
      end else begin
         mul_ready = 0; mul_result = 31'($urandom); mul_err_in = 1'($urandom_range(0, 1));
      end
      #1;

      for (int i = 0; i < 2; i++) elig[i] = pend[i] && (mout[i] < MAX_OUT);
      g = -1;
      if (elig[0] && elig[1]) g = mlast ? 0 : 1;
      else if (elig[0]) g = 0;
      else if (elig[1]) g = 1;
      chk("req0_ready", req0_ready, (g == 0));
      chk("req1_ready", req1_ready, (g == 1));
      if (req0_valid && req0_ready) begin obs_hs0++; gseq.push_back(0); end
      if (req1_valid && req1_ready) gseq.push_back(1);

      e_mv = 0; e_rv[0] = 0; e_rv[1] = 0;
      if (!rst_n) begin
         model_reset();
         foreach (q[k]) q[k].stale = 1;
         if (due_now) void'(q.pop_front());
      end else begin
         if (due_now) begin
            op = q.pop_front();
            if (!op.stale) begin
               mout[op.id]--;
               if (op.lose) e_proto = 1;
               else begin
                  e_rv[op.id] = 1; e_rd[op.id] = op.res; e_re[op.id] = op.err;
               end
            end
         end
         if (g >= 0) begin
            e_mv = 1; e_ma = pa[g]; e_mb = pb[g]; e_me = perr[g];
            mout[g]++; mlast = (g == 1); pend[g] = 0;
            op.due   = cyc + 1 + LAT;
            op.id    = (g == 1);
            op.res   = fmul(pa[g], pb[g]);
            op.err   = perr[g] ^ ($urandom_range(0, 99) < flip_pct);
            op.lose  = lose_next || ($urandom_range(0, 99) < lose_pct);
            op.stale = 0;
            lose_next = 0;
            q.push_back(op);
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      pct[0] = 0; pct[1] = 0;
      while ((q.size() != 0 || pend[0] || pend[1]) && n < 100) begin
         step(); n++;
      end
      chk("drain_done", (q.size() == 0 && !pend[0] && !pend[1]), 1'b1);
      step(); step();
   endtask

   task automatic issue_dir(input int id, input logic [30:0] a, input logic [30:0] b, input logic err);
      dir_en = 1; dir_id = id; dir_a = a; dir_b = b; dir_err = err;
      step();
   endtask

   initial begin
      rst_n = 0;
      req0_valid = 0; req0_a = '0; req0_b = '0; req0_err = 0;
      req1_valid = 0; req1_a = '0; req1_b = '0; req1_err = 0;
      mul_ready = 0; mul_result = '0; mul_err_in = 0;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         pend[i] = 0; pa[i] = '0; pb[i] = '0; perr[i] = 0; pct[i] = 0;
      end
      lose_pct = 0; flip_pct = 0; rst_pct = 0; lose_next = 0; dir_en = 0;
      obs_hs0 = 0; obs_rsp0 = 0; hs_at_first_rsp0 = -1;

      // Reset state
      for (int k = 0; k < 3; k++) begin rst_now = 1; step(); end
      step();

      // Contention: both valid continuously, grants alternate from req0
      gseq.delete();
      pct[0] = 100; pct[1] = 100;
      for (int k = 0; k < 6; k++) step();
      drain();
      chk("contention_len", (gseq.size() >= 6), 1'b1);
      for (int k = 0; k < 6 && k < gseq.size(); k++)
         chk("contention_grant", 32'(gseq[k]), 32'(k % 2));

      // Single op 1.0 * 2.0
      issue_dir(0, 31'h3F800000, 31'h40000000, 1'b0);
      drain();
      chk("single_rsp0_data", rsp0_data, 31'h40000000);

      // Outstanding limit on req0 with req1 idle
      obs_hs0 = 0; obs_rsp0 = 0; hs_at_first_rsp0 = -1;
      pct[0] = 100;
      for (int k = 0; k < 20; k++) step();
      drain();
      chk("limit_hs_before_rsp", hs_at_first_rsp0, MAX_OUT);

      // Error pass-through on requester 1
      issue_dir(1, 31'h40400000, 31'h3FC00000, 1'b1);
      drain();
      chk("err_rsp1_err", rsp1_err, 1'b1);
      chk("err_proto_clean", proto_err, 1'b0);

      // Lost result, then a normal op
      lose_next = 1;
      issue_dir(0, 31'h40800000, 31'h40000000, 1'b0);
      drain();
      chk("lost_proto", proto_err, 1'b1);
      issue_dir(0, 31'h40000000, 31'h40000000, 1'b0);
      drain();
      chk("after_lost_data", rsp0_data, 31'h40800000);

      // Reset mid-flight with stale results returning afterwards
      issue_dir(0, 31'h41000000, 31'h40000000, 1'b0);
      issue_dir(0, 31'h41100000, 31'h40000000, 1'b0);
      rst_now = 1;
      step();
      drain();
      chk("rst_proto_clear", proto_err, 1'b0);
      chk("rst_rsp0_data", rsp0_data, 31'h0);
      issue_dir(0, 31'h3F800000, 31'h40400000, 1'b0);
      drain();
      chk("rst_next_op", rsp0_data, 31'h40400000);

      // Randomised traffic with occasional losses, error flips and resets
      lose_pct = 3; flip_pct = 10; rst_pct = 4;
      for (int k = 0; k < 400; k++) begin
         pct[0] = $urandom_range(0, 100); pct[1] = $urandom_range(0, 100);
         step();
      end
      rst_pct = 0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
